// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer drives tx_data/tx_valid; the transmitter reports tx_ready/tx_busy.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;

    modport master (output tx_data, output tx_valid, input tx_ready, input tx_busy);
    modport slave  (input tx_data, input tx_valid, output tx_ready, output tx_busy);
endinterface

// File: rtl/uart_tx.sv
// 8-bit LSB-first UART transmitter with a one-deep holding register for gapless frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int DIVISOR   = CLK_FREQ / BAUD,
    parameter int STOP_BITS = 1
) (
    input  logic       sysclk,
    input  logic       reset,
    uart_tx_if.slave   bus,
    output logic       txd
);
    localparam int CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam bit TWO_STP = (STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_valid_q, hold_valid_d;
    logic          txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic accept, baud_end, consumed;

    assign accept       = bus.tx_valid && !hold_valid_q;
    assign baud_end     = (baud_q == CW'(DIVISOR - 1));
    assign bus.tx_ready = !hold_valid_q;
    assign bus.tx_busy  = (state_q != IDLE) || hold_valid_q;
    assign txd          = txd_q;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            txd_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            txd_q        <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        txd_d        = txd_q;
        consumed     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d        = par_q;
`endif
        // Baud phase restarts on every bit boundary; a new frame always starts at 0.
        if (state_q != IDLE) baud_d = baud_end ? '0 : baud_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = START;
                    shift_d  = bus.tx_data;
                    txd_d    = 1'b0;
                    baud_d   = '0;
                    consumed = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d    = ^bus.tx_data;
`endif
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = par_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    if (TWO_STP && bit_q == 3'd0) begin
                        bit_d = 3'd1;
                    end else if (hold_valid_q) begin
                        state_d      = START;
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                        txd_d        = 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_d        = ^hold_q;
`endif
                    end else if (accept) begin
                        // Byte arriving on the closing edge goes straight to the shifter.
                        state_d  = START;
                        shift_d  = bus.tx_data;
                        txd_d    = 1'b0;
                        consumed = 1'b1;
`ifdef UART_TX_PARITY_EN
                        par_d    = ^bus.tx_data;
`endif
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        if (accept && !consumed) begin
            hold_d       = bus.tx_data;
            hold_valid_d = 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench: DIVISOR=16 with two stop bits, plus a truncated-divisor instance
// (105/10 -> 10) with STOP_BITS=3, which must behave as one stop bit.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int D1  = 16;
    localparam int FL1 = (1 + 8 + PAR + 2) * D1;
    localparam int D2  = 10;
    localparam int FL2 = (1 + 8 + PAR + 1) * D2;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    logic txd1, txd2;
    int   ntests = 0;
    int   nfail  = 0;
    logic [7:0] cyc   = 8'h00;
    logic [7:0] third;

    uart_tx_if bus1();
    uart_tx_if bus2();

    uart_tx #(.CLK_FREQ(160), .BAUD(10), .STOP_BITS(2)) dut1 (
        .sysclk(sysclk), .reset(reset), .bus(bus1.slave), .txd(txd1));
    uart_tx #(.CLK_FREQ(105), .BAUD(10), .STOP_BITS(3)) dut2 (
        .sysclk(sysclk), .reset(reset), .bus(bus2.slave), .txd(txd2));

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected line level for bit slot k of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic send1(input logic [7:0] b);
        bus1.tx_valid = 1'b1;
        bus1.tx_data  = b;
        step();
        bus1.tx_valid = 1'b0;
    endtask

    // Starts on the sample right after the edge that launched the start bit.
    task automatic frame(input logic [7:0] b, input int inj, input logic [7:0] nb,
                         input int rel, input int lo_from, input string tag);
        for (int j = 0; j < FL1; j++) begin
            chk($sformatf("%s.txd[%0d]", tag, j), txd1, exp_bit(b, j / D1));
            chk($sformatf("%s.ready[%0d]", tag, j), bus1.tx_ready,
                (lo_from >= 0 && j >= lo_from) ? 1'b0 : 1'b1);
            chk($sformatf("%s.busy[%0d]", tag, j), bus1.tx_busy, 1'b1);
            if (j == inj) begin
                bus1.tx_valid = 1'b1;
                bus1.tx_data  = nb;
            end else if (j == rel) begin
                bus1.tx_valid = 1'b0;
            end else if (inj >= 0 && j > inj) begin
                bus1.tx_data = cyc;
                cyc++;
            end
            step();
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".txd"},   txd1,          1'b1);
        chk({tag, ".ready"}, bus1.tx_ready, 1'b1);
        chk({tag, ".busy"},  bus1.tx_busy,  1'b0);
    endtask

    initial begin
        bus1.tx_valid = 1'b0; bus1.tx_data = 8'h00;
        bus2.tx_valid = 1'b0; bus2.tx_data = 8'h00;
        #12;
        idle_chk("rst");
        chk("rst.txd2",   txd2,         1'b1);
        chk("rst.busy2",  bus2.tx_busy, 1'b0);
        reset = 1'b1;
        step();

        // Single frame, ready never drops
        send1(8'h41);
        frame(8'h41, -1, 8'h00, -1, -1, "f41");
        idle_chk("f41.end");

        // 0xBE held during data bit 2, then tx_valid kept high with cycling data
        step();
        send1(8'h41);
        frame(8'h41, 4 * D1 - 11, 8'hBE, -1, 4 * D1 - 10, "b2b41");
        third = bus1.tx_data;
        frame(8'hBE, -1, 8'h00, 1, 1, "b2bBE");
        frame(third, -1, 8'h00, -1, -1, "b2b3rd");
        idle_chk("b2b.end");

        // Async reset mid data bit 3 of 0x55
        step();
        send1(8'h55);
        for (int j = 0; j < 4 * D1 + 5; j++) step();
        reset = 1'b0;
        #1;
        chk("arst.txd",   txd1,          1'b1);
        chk("arst.ready", bus1.tx_ready, 1'b1);
        chk("arst.busy",  bus1.tx_busy,  1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        send1(8'h42);
        frame(8'h42, -1, 8'h00, -1, -1, "f42");
        idle_chk("f42.end");

        // Truncated divisor, STOP_BITS=3 acts as a single stop bit
        bus2.tx_valid = 1'b1;
        bus2.tx_data  = 8'hA5;
        step();
        bus2.tx_valid = 1'b0;
        for (int j = 0; j < FL2; j++) begin
            chk($sformatf("d2.txd[%0d]", j), txd2, exp_bit(8'hA5, j / D2));
            chk($sformatf("d2.busy[%0d]", j), bus2.tx_busy, 1'b1);
            step();
        end
        chk("d2.end.txd",  txd2,         1'b1);
        chk("d2.end.busy", bus2.tx_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-to-serial UART transmitter, 8 data bits, LSB first, 1 or 2 stop bits; the drive end of the serial line that the receive path samples.
- Takes bytes through a valid/ready handshake and shifts them out on txd at a baud rate derived from sysclk.
- One-deep holding register accepts the next byte during a frame, so consecutive frames go out with no idle gap.

Parameters:
- CLK_FREQ, 50000000, sysclk frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- DIVISOR, CLK_FREQ/BAUD (truncating, 5208 at defaults), sysclk cycles per bit.
- STOP_BITS, 1, number of stop bits; 2 selects two, any other value behaves as 1.

Ports:
- sysclk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send, sampled only on accept.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register empty, byte can be accepted.
- tx_busy  output  1  a frame is in progress or a byte is held.
- txd  output  1  serial line, idle high.

Behaviour:
- Reset (reset=0, async): txd=1, tx_ready=1, tx_busy=0, FSM=IDLE, baud/bit counters=0, hold_valid=0. A frame or held byte in progress at reset is discarded. txd returns to 1 immediately, not at the next edge.
- Accept: tx_valid&&tx_ready on a rising edge. tx_valid is ignored while tx_ready=0. tx_data is a don't-care outside accept.
- tx_ready = ~hold_valid. tx_busy = (FSM!=IDLE) | hold_valid.
- Accept while FSM=IDLE: byte goes directly into the shifter, bypassing the hold register. FSM enters START and txd=0 on the same edge. tx_ready stays 1.
- Accept while FSM!=IDLE: byte goes into the hold register, hold_valid=1, tx_ready=0 from the next cycle.
- FSM states: IDLE -> START -> DATA (bits 0..7) -> [PARITY] -> STOP (STOP_BITS bits) -> IDLE or START.
- Each bit lasts exactly DIVISOR cycles. The baud counter counts 0..DIVISOR-1 and restarts at every bit boundary and at frame start, so there is no phase carry-over between frames.
- txd is registered: START=0, DATA=shift[0] with right shift per bit, STOP=1, IDLE=1.
- End of last stop bit (baud counter = DIVISOR-1, last stop bit):
  - hold_valid=1: load shifter from hold, clear hold_valid, go to START. txd falls on that same edge, so there is no idle gap. tx_ready=1 the following cycle.
  - hold_valid=0: go to IDLE.
- Frame length: (1+8+STOP_BITS)*DIVISOR cycles; 52080 at defaults.
- No simultaneous accept-and-drain conflict: tx_ready=0 whenever hold is full.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after data bit 7, lasting DIVISOR cycles. txd carries even parity, the XOR of the 8 data bits. Frame length is (10+STOP_BITS)*DIVISOR.
- Undefined: no PARITY state and no parity logic; the frame is 8N1 / 8N2.

Test Plan:
- Defaults, accept 0x41 one cycle after reset release -> txd low for 5208 cycles, then 1,0,0,0,0,0,1,0 at 5208 cycles each, then high. tx_busy=1 for 52080 cycles then 0. tx_ready stays 1.
- Accept 0x41, then 0xBE during data bit 2 -> tx_ready=0 until the 0x41 stop bit ends. The 0xBE start bit begins on the cycle after the stop bit with no idle gap. tx_ready=1 one cycle later.
- Hold full, tx_valid held high with tx_data cycling 0x00..0xFF -> nothing accepted. Only 0x41 and 0xBE appear on txd. The first value present when tx_ready rises is the third byte sent.
- Assert reset during data bit 3 of 0x55 -> txd=1, tx_ready=1, tx_busy=0 asynchronously. After release, accept 0x42 -> one clean frame with 0x42 and no remnant of 0x55.
- CLK_FREQ=160, BAUD=10 (DIVISOR=16), STOP_BITS=2, send 0x00 then 0xFF back-to-back -> every bit exactly 16 cycles, two 16-cycle stop bits, frame 176 cycles.
- UART_TX_PARITY_EN, defaults, send 0x41 then 0x43 -> parity bits 0 then 1. Each frame 57288 cycles, with the stop bit after the parity bit.
